// File: rtl/ps_sample_reader.sv
// ps_sample_reader
// Producer side of the 18-bit proximity-sample bus. On every sample tick it
// reads three consecutive sensor registers, one byte-read request each,
// assembles PS_DATA = {byte2[1:0], byte1, byte0}, strobes PS_VALID, and keeps
// a saturating count of failed sample attempts (NACK/bus error or timeout).
module ps_sample_reader #(
  parameter int unsigned SAMPLE_PERIOD = 500000,  // cycles between ticks, >= 8
  parameter int unsigned TIMEOUT       = 100000,  // max cycles RD_REQ may wait
  parameter logic [7:0]  BASE_ADDR     = 8'h08    // register of the data LSB
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic        RD_REQ,
  output logic [7:0]  RD_ADDR,
  input  logic        RD_DONE,
  input  logic [7:0]  RD_DATA,
  input  logic        RD_ERR,
  output logic [17:0] PS_DATA,
  output logic        PS_VALID,
  output logic        BUSY,
  output logic [7:0]  ERR_CNT
);

  // Counter widths: the period counter spans 0..SAMPLE_PERIOD-1, the timeout
  // counter spans 0..TIMEOUT-1 (at least one bit even for TIMEOUT=1).
  localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [PER_W-1:0] r_period_cnt;
  logic [TO_W-1:0]  r_tcnt;
  logic [1:0]       r_state;
  logic [1:0]       r_index;
  logic [7:0]       r_err_cnt;
  logic             r_ps_valid;
  logic [17:0]      r_ps_data;
  logic [7:0]       r_byte0;
  logic [7:0]       r_byte1;
  logic [1:0]       r_byte2_lo;

  logic w_tick;
  logic w_timeout;
  logic w_accept;
  logic w_fail;

  // A tick only exists while sampling is enabled; the counter is parked at 0
  // otherwise, so the enable term just makes that explicit.
  assign w_tick    = ENABLE && (r_period_cnt == PER_LAST);
  assign w_timeout = (r_tcnt == TO_LAST);

  // A completed byte read wins over a timeout landing in the same cycle.
  assign w_accept  = (r_state == S_READ) && RD_DONE && !RD_ERR;
  assign w_fail    = (r_state == S_READ) && ((RD_DONE && RD_ERR) || (!RD_DONE && w_timeout));

  // Free-running sample period counter, independent of the FSM state.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      r_period_cnt <= '0;
    end else if (r_period_cnt == PER_LAST) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + PER_ONE;
    end
  end

  // Read sequencer: IDLE -> (READ -> GAP)x2 -> READ -> COMMIT -> IDLE.
  // Ticks outside IDLE are simply ignored, never queued.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_index    <= 2'd0;
      r_tcnt     <= '0;
      r_err_cnt  <= 8'd0;
      r_ps_valid <= 1'b0;
    end else begin
      r_ps_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_READ;
            r_index <= 2'd0;
            r_tcnt  <= '0;
          end
        end
        S_READ: begin
          if (w_accept) begin
            if (r_index == 2'd2) begin
              r_state <= S_COMMIT;
            end else begin
              r_index <= r_index + 2'd1;
              r_state <= S_GAP;
            end
          end else if (w_fail) begin
            r_state <= S_IDLE;
            r_index <= 2'd0;
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
          end else begin
            r_tcnt <= r_tcnt + TO_ONE;
          end
        end
        S_GAP: begin
          r_tcnt  <= '0;
          r_state <= S_READ;
        end
        S_COMMIT: begin
          r_ps_valid <= 1'b1;
          r_index    <= 2'd0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte capture; only byte2[1:0] contributes to the sample word.
  // Every byte is rewritten before a commit, so a failed attempt leaves
  // nothing behind that could leak into a later sample.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      case (r_index)
        2'd0:    r_byte0    <= RD_DATA;
        2'd1:    r_byte1    <= RD_DATA;
        default: r_byte2_lo <= RD_DATA[1:0];
      endcase
    end
  end

  // Published sample: changes only on commit, so failed attempts keep the
  // previous value. Becomes visible together with the PS_VALID strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ps_data <= 18'd0;
    end else if (r_state == S_COMMIT) begin
      r_ps_data <= {r_byte2_lo, r_byte1, r_byte0};
    end
  end

  assign RD_REQ   = (r_state == S_READ);
  assign RD_ADDR  = BASE_ADDR + {6'd0, r_index};
  assign BUSY     = (r_state != S_IDLE);
  assign PS_DATA  = r_ps_data;
  assign PS_VALID = r_ps_valid;
  assign ERR_CNT  = r_err_cnt;

endmodule

// File: tb/tb_ps_sample_reader.sv
// Testbench for ps_sample_reader: table of whole-sample transactions served by
// a directed master, plus hand-written sequences for timeout, error-counter
// saturation, enable removal mid-sample, stray RD_DONE and reset mid-read.
module tb_ps_sample_reader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        RD_REQ;
  logic [7:0]  RD_ADDR;
  logic        RD_DONE;
  logic [7:0]  RD_DATA;
  logic        RD_ERR;
  logic [17:0] PS_DATA;
  logic        PS_VALID;
  logic        BUSY;
  logic [7:0]  ERR_CNT;

  ps_sample_reader #(
    .SAMPLE_PERIOD (16),
    .TIMEOUT       (20),
    .BASE_ADDR     (8'h08)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .RD_REQ   (RD_REQ),
    .RD_ADDR  (RD_ADDR),
    .RD_DONE  (RD_DONE),
    .RD_DATA  (RD_DATA),
    .RD_ERR   (RD_ERR),
    .PS_DATA  (PS_DATA),
    .PS_VALID (PS_VALID),
    .BUSY     (BUSY),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          err_at;    // byte index answered with RD_ERR, 3 = none
    int          dly;       // cycles RD_REQ is held before RD_DONE
    logic [17:0] exp_data;  // PS_DATA after this attempt
    logic [7:0]  exp_err;   // ERR_CNT after this attempt
  } vec_t;

  vec_t vecs [8];

  int n_checks = 0;
  int n_err    = 0;
  int exp_valid_total = 0;

  // Monitor: samples the values that were stable during the finished cycle.
  int   cyc        = 0;
  int   valid_cnt  = 0;
  int   last_start = 0;
  logic prev_busy  = 1'b0;
  always @(posedge CLK) begin
    if (PS_VALID) valid_cnt <= valid_cnt + 1;
    if (RD_REQ && !prev_busy) last_start <= cyc;
    prev_busy <= BUSY;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic wait_req(input int bound, output bit ok);
    int n;
    n = 0;
    while (!RD_REQ && n < bound) begin
      @(negedge CLK);
      n++;
    end
    ok = RD_REQ;
  endtask

  // Serve one full sample attempt; called at a negedge while RD_REQ is low.
  task automatic run_sample(input vec_t v, input bit drop_en);
    bit ok;
    logic [7:0] d;
    for (int b = 0; b < 3; b++) begin
      wait_req(40, ok);
      if (!ok) begin
        chk("req_seen", {31'd0, ok}, 32'd1);
        return;
      end
      if (b == 0) begin
        chk("valid_count", valid_cnt, exp_valid_total);
        if (drop_en) ENABLE = 1'b0;
      end
      chk("rd_addr", {24'd0, RD_ADDR}, 32'h08 + b);
      repeat (v.dly) @(negedge CLK);
      d = (b == 0) ? v.b0 : (b == 1) ? v.b1 : v.b2;
      RD_DONE = 1'b1;
      RD_DATA = d;
      RD_ERR  = (v.err_at == b);
      @(negedge CLK);
      RD_DONE = 1'b0;
      RD_ERR  = 1'b0;
      RD_DATA = 8'h00;
      if (v.err_at == b) begin
        chk("abort_req",   {31'd0, RD_REQ},   32'd0);
        chk("abort_busy",  {31'd0, BUSY},     32'd0);
        chk("abort_valid", {31'd0, PS_VALID}, 32'd0);
        chk("abort_data",  {14'd0, PS_DATA},  {14'd0, v.exp_data});
        chk("abort_err",   {24'd0, ERR_CNT},  {24'd0, v.exp_err});
        return;
      end
      if (b < 2) begin
        chk("gap_req",  {31'd0, RD_REQ}, 32'd0);
        chk("gap_busy", {31'd0, BUSY},   32'd1);
        @(negedge CLK);
        chk("gap_len",  {31'd0, RD_REQ}, 32'd1);
      end
    end
    chk("commit_busy",  {31'd0, BUSY},     32'd1);
    chk("commit_req",   {31'd0, RD_REQ},   32'd0);
    chk("commit_early", {31'd0, PS_VALID}, 32'd0);
    @(negedge CLK);
    chk("ps_valid", {31'd0, PS_VALID}, 32'd1);
    chk("ps_data",  {14'd0, PS_DATA},  {14'd0, v.exp_data});
    chk("err_cnt",  {24'd0, ERR_CNT},  {24'd0, v.exp_err});
    exp_valid_total++;
  endtask

  // Watchdog so the run always ends.
  initial begin
    repeat (20000) @(posedge CLK);
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   n;
    int   ref_start;
    vec_t v;

    //           b0     b1     b2    err dly  PS_DATA     ERR_CNT
    vecs[0] = '{8'h34, 8'h12, 8'hFF, 3,  5,  18'h31234, 8'd0};
    vecs[1] = '{8'h77, 8'h88, 8'h99, 1,  2,  18'h31234, 8'd1};
    vecs[2] = '{8'hAB, 8'hCD, 8'h02, 3,  0,  18'h2CDAB, 8'd1};
    vecs[3] = '{8'h00, 8'h00, 8'hFC, 3,  1,  18'h00000, 8'd1};
    vecs[4] = '{8'h44, 8'h55, 8'h66, 0,  4,  18'h00000, 8'd2};
    vecs[5] = '{8'h5A, 8'hA5, 8'h01, 3,  17, 18'h1A55A, 8'd2};
    vecs[6] = '{8'hEE, 8'hDD, 8'hCC, 2,  3,  18'h1A55A, 8'd3};
    vecs[7] = '{8'h01, 8'h02, 8'h03, 3,  0,  18'h30201, 8'd3};

    RESET   = 1'b1;
    ENABLE  = 1'b0;
    RD_DONE = 1'b0;
    RD_DATA = 8'h00;
    RD_ERR  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_req",   {31'd0, RD_REQ},   32'd0);
    chk("rst_addr",  {24'd0, RD_ADDR},  32'h08);
    chk("rst_data",  {14'd0, PS_DATA},  32'd0);
    chk("rst_valid", {31'd0, PS_VALID}, 32'd0);
    chk("rst_busy",  {31'd0, BUSY},     32'd0);
    chk("rst_err",   {24'd0, ERR_CNT},  32'd0);
    RESET = 1'b0;

    // Disabled: no requests; a stray RD_DONE in IDLE is ignored.
    n = 0;
    repeat (40) begin
      @(negedge CLK);
      if (RD_REQ || BUSY) n++;
    end
    chk("disabled_quiet", n, 0);
    RD_DONE = 1'b1;
    RD_ERR  = 1'b1;
    RD_DATA = 8'h55;
    @(negedge CLK);
    RD_DONE = 1'b0;
    RD_ERR  = 1'b0;
    RD_DATA = 8'h00;
    @(negedge CLK);
    chk("stray_busy", {31'd0, BUSY},    32'd0);
    chk("stray_err",  {24'd0, ERR_CNT}, 32'd0);
    chk("stray_data", {14'd0, PS_DATA}, 32'd0);

    // Table of sample attempts, back to back with ENABLE held high.
    ENABLE = 1'b1;
    ref_start = 0;
    for (int i = 0; i < 8; i++) begin
      run_sample(vecs[i], 1'b0);
      if (i == 0) ref_start = last_start;
      else chk("tick_phase", (last_start - ref_start) % 16, 0);
    end

    // Unresponsive master: RD_REQ held exactly TIMEOUT cycles, then retried.
    for (int k = 0; k < 2; k++) begin
      wait_req(40, ok);
      chk("to_req_seen", {31'd0, ok}, 32'd1);
      chk("to_addr", {24'd0, RD_ADDR}, 32'h08);
      n = 0;
      while (RD_REQ && n < 100) begin
        @(negedge CLK);
        n++;
      end
      chk("to_req_cycles", n, 20);
      chk("to_busy", {31'd0, BUSY},    32'd0);
      chk("to_err",  {24'd0, ERR_CNT}, 32'd4 + k);
      chk("to_data", {14'd0, PS_DATA}, 32'h30201);
    end

    // 300 consecutive errored attempts: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      wait_req(40, ok);
      if (!ok) begin
        chk("sat_req_seen", {31'd0, ok}, 32'd1);
        break;
      end
      RD_DONE = 1'b1;
      RD_ERR  = 1'b1;
      @(negedge CLK);
      RD_DONE = 1'b0;
      RD_ERR  = 1'b0;
      if (i == 248) chk("sat_err_254", {24'd0, ERR_CNT}, 32'hFE);
    end
    chk("sat_err", {24'd0, ERR_CNT}, 32'hFF);
    chk("sat_data", {14'd0, PS_DATA}, 32'h30201);

    // ENABLE removed during the first read: sample completes, then silence.
    v = '{8'h11, 8'h22, 8'h33, 3, 2, 18'h32211, 8'hFF};
    run_sample(v, 1'b1);
    n = 0;
    repeat (40) begin
      @(negedge CLK);
      if (RD_REQ || BUSY) n++;
    end
    chk("en_off_quiet", n, 0);
    chk("en_off_valid_count", valid_cnt, exp_valid_total);

    // Reset during the second byte read.
    ENABLE = 1'b1;
    wait_req(40, ok);
    chk("rr_req_seen", {31'd0, ok}, 32'd1);
    RD_DONE = 1'b1;
    RD_DATA = 8'h99;
    @(negedge CLK);
    RD_DONE = 1'b0;
    @(negedge CLK);
    chk("rr_in_read", {31'd0, RD_REQ}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rr_req",  {31'd0, RD_REQ},   32'd0);
    chk("rr_busy", {31'd0, BUSY},     32'd0);
    chk("rr_err",  {24'd0, ERR_CNT},  32'd0);
    chk("rr_data", {14'd0, PS_DATA},  32'd0);
    chk("rr_addr", {24'd0, RD_ADDR},  32'h08);
    RESET = 1'b0;

    // Recovery after reset.
    run_sample(vecs[0], 1'b0);
    @(negedge CLK);
    chk("final_valid_count", valid_cnt, exp_valid_total);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
